// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: widths, FSM states and round constants.
package aes_pkg;

  localparam int unsigned RK_W   = 128;
  localparam int unsigned NUM_RK = 11;
  localparam int unsigned BANK_W = RK_W * NUM_RK;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Rcon[1..10] top byte; any other index returns 0.
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/sbox.sv
// AES forward S-box lookup.
module sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign s = SBOX[a];

endmodule

// File: rtl/subword.sv
// SubWord: byte-wise S-box substitution of a 32-bit word.
module subword (
  input  logic [31:0] w,
  output logic [31:0] s
);

  for (genvar b = 0; b < 4; b++) begin : g_byte
    sbox u_sbox (
      .a (w[8*b +: 8]),
      .s (s[8*b +: 8])
    );
  end

endmodule

// File: rtl/aes_key_scheduler.sv
// Iterative AES-128 key expansion into a registered 11-entry round-key bank,
// one round key per clock, exposed flat and through an indexed read port.
module aes_key_scheduler
  import aes_pkg::*;
#(
  parameter int unsigned NR    = 10,
  parameter int unsigned KEY_W = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [KEY_W-1:0]          key,
  output logic                      busy,
  output logic                      ready,
  input  logic [3:0]                rk_idx,
  output logic [KEY_W-1:0]          rk,
  output logic [(NR+1)*KEY_W-1:0]   words
);

  state_t           state_q, state_d;
  logic [3:0]       rnd_q, rnd_d;
  logic             load_key, write_rnd;
  logic [KEY_W-1:0] bank_q [NR+1];

  logic [3:0]       prev_idx;
  logic [KEY_W-1:0] prev, next_rk;
  logic [31:0]      w3, rot, sub, t, n0, n1, n2, n3;

  // Round datapath: only the current round is computed each cycle.
  assign prev_idx = (rnd_q == 4'd0) ? 4'd0 : rnd_q - 4'd1;
  assign prev     = bank_q[prev_idx];
  assign w3       = prev[31:0];
  assign rot      = {w3[23:0], w3[31:24]};

  subword u_subword (
    .w (rot),
    .s (sub)
  );

  assign t       = sub ^ {rcon(rnd_q), 24'h000000};
  assign n0      = prev[127:96] ^ t;
  assign n1      = prev[95:64]  ^ n0;
  assign n2      = prev[63:32]  ^ n1;
  assign n3      = w3           ^ n2;
  assign next_rk = {n0, n1, n2, n3};

  // Next state and bank write controls.
  always_comb begin
    state_d   = state_q;
    rnd_d     = rnd_q;
    load_key  = 1'b0;
    write_rnd = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = EXPAND;
          rnd_d    = 4'd1;
          load_key = 1'b1;
        end
      end
      EXPAND: begin
        write_rnd = 1'b1;
        if (rnd_q == 4'(NR)) state_d = DONE;
        else                 rnd_d   = rnd_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rnd_q   <= 4'd0;
      busy    <= 1'b0;
      ready   <= 1'b0;
      for (int unsigned i = 0; i <= NR; i++) bank_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      busy    <= (state_d == EXPAND);
      ready   <= (state_d == DONE);
      if (load_key)       bank_q[0]     <= key;
      else if (write_rnd) bank_q[rnd_q] <= next_rk;
    end
  end

  assign rk = (rk_idx <= 4'(NR)) ? bank_q[rk_idx] : '0;

  for (genvar r = 0; r <= NR; r++) begin : g_words
    assign words[(NR+1)*KEY_W-1-KEY_W*r -: KEY_W] = bank_q[r];
  end

endmodule

// File: tb/tb_aes_key_scheduler.sv
// Self-checking bench for aes_key_scheduler against an arithmetic AES reference.
module tb_aes_key_scheduler;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [127:0]  key;
  logic [3:0]    rk_idx;
  logic          busy, ready;
  logic [127:0]  rk;
  logic [1407:0] words;

  int total = 0;
  int bad   = 0;

  logic [7:0]   ref_sb [256];
  logic [127:0] exp_rk [11];
  logic [127:0] dut_rk [11];

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  aes_key_scheduler dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .key    (key),
    .busy   (busy),
    .ready  (ready),
    .rk_idx (rk_idx),
    .rk     (rk),
    .words  (words)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from the field inverse (v^254) followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      if (v != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(v));
      end
      s = 8'h63 ^ inv;
      for (int k = 1; k <= 4; k++) s = s ^ 8'((inv << k) | (inv >> (8 - k)));
      ref_sb[v] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {ref_sb[w[31:24]], ref_sb[w[23:16]], ref_sb[w[15:8]], ref_sb[w[7:0]]};
  endfunction

  // Word-recurrence key expansion w[i] = w[i-4] ^ f(w[i-1]).
  task automatic model(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] st = pt ^ dut_rk[0];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = ref_sb[st[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) t[w + 4*c] = s[w + 4*((c + w) % 4)];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) st[127-8*i -: 8] = s[i];
      st = st ^ dut_rk[r];
    end
    return st;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start an expansion and follow it to ready; optionally poke start/key at cycle glitch_at.
  task automatic run_key(input logic [127:0] k, input int glitch_at, input logic [127:0] gkey);
    int n;
    key   = k;
    start = 1'b1;
    tick();
    start = 1'b0;
    key   = ~k;
    n     = 1;
    chk("busy_after_start", 128'(busy), 128'd1);
    chk("ready_after_start", 128'(ready), 128'd0);
    chk("round0_loaded", words[1407:1280], k);
    while (!ready && n < 20) begin
      chk("busy_during_expand", 128'(busy), 128'd1);
      if (n == glitch_at) begin
        start = 1'b1;
        key   = gkey;
      end
      tick();
      start = 1'b0;
      n++;
    end
    chk("edges_to_ready", 128'(n), 128'd11);
    chk("busy_in_done", 128'(busy), 128'd0);
  endtask

  task automatic check_words(input string tag);
    for (int r = 0; r < 11; r++) chk(tag, words[1407-128*r -: 128], exp_rk[r]);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    key    = '0;
    rk_idx = 4'd0;
    build_sbox();
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();

    chk("idle_busy", 128'(busy), 128'd0);
    chk("idle_ready", 128'(ready), 128'd0);
    for (int r = 0; r < 11; r++) chk("idle_words", words[1407-128*r -: 128], 128'd0);
    for (int i = 0; i < 16; i++) begin
      rk_idx = 4'(i);
      #1;
      chk("idle_rk", rk, 128'd0);
    end
    tick();

    // FIPS-197 C.1 key
    model(KEY_C1);
    run_key(KEY_C1, -1, '0);
    check_words("c1_bank");
    chk("c1_words_top", words[1407:1280], KEY_C1);
    rk_idx = 4'd1;
    #1 chk("c1_rk1", rk, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    rk_idx = 4'd10;
    #1 chk("c1_rk10", rk, 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // FIPS-197 A.1 key, started in the first DONE cycle
    model(KEY_A1);
    run_key(KEY_A1, -1, '0);
    check_words("a1_bank");
    rk_idx = 4'd1;
    #1 chk("a1_rk1", rk, 128'ha0fafe1788542cb123a339392a6c7605);
    rk_idx = 4'd10;
    #1 chk("a1_rk10", rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // start plus a different key mid-expansion is ignored
    model(KEY_C1);
    run_key(KEY_C1, 4, KEY_A1);
    check_words("glitch_bank");

    // out-of-range read index while ready
    for (int i = 11; i < 16; i++) begin
      rk_idx = 4'(i);
      #1;
      chk("rk_idx_oob", rk, 128'd0);
    end

    // cipher integration on the C.1 bank
    for (int r = 0; r < 11; r++) dut_rk[r] = words[1407-128*r -: 128];
    chk("cipher_c1", aes_enc(128'h00112233445566778899aabbccddeeff),
        128'h69c4e0d86a7b0430d8cdb78070b4c55a);

    // asynchronous reset mid-expansion
    key   = KEY_A1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_ready", 128'(ready), 128'd0);
    rk_idx = 4'd0;
    #1 chk("rst_rk0", rk, 128'd0);
    for (int r = 0; r < 11; r++) chk("rst_words", words[1407-128*r -: 128], 128'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_ready", 128'(ready), 128'd0);
    model(KEY_C1);
    run_key(KEY_C1, -1, '0);
    rk_idx = 4'd10;
    #1 chk("post_rst_rk10", rk, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    check_words("post_rst_bank");

    // random keys against the reference expansion
    for (int j = 0; j < 4; j++) begin
      logic [127:0] rkey;
      rkey = {$urandom, $urandom, $urandom, $urandom};
      model(rkey);
      run_key(rkey, (j == 1) ? 7 : -1, ~rkey);
      check_words("rand_bank");
      rk_idx = 4'($urandom_range(0, 10));
      #1 chk("rand_rk", rk, exp_rk[rk_idx]);
      repeat (j) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_key_scheduler.md
# aes_key_scheduler

Sequential AES-128 key schedule that expands a 128-bit cipher key into the 11 round keys over 10 clock cycles, one round key per cycle. It sits directly upstream of the iterative cipher. It replaces the purely combinational expansion with a registered 11-entry round-key bank. The bank is exposed in the same flat 1408-bit layout the cipher already consumes, plus an indexed read port.

## Interface

Parameters:
- NR, 10: number of rounds; only 10 (AES-128) is supported.
- KEY_W, 128: key and round-key width; fixed at 128.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle request to latch `key` and begin expansion.
- key  input  128  cipher key; sampled only on the edge where `start` is accepted.
- busy  output  1  high while expansion is in progress.
- ready  output  1  high when all 11 round keys are valid.
- rk_idx  input  4  round-key read index, 0..10.
- rk  output  128  round key `rk_idx`, combinational read of the bank.
- words  output  1408  full bank, round 0 at [1407:1280] and round r at [1407-128r -: 128]; round 10 at [127:0].

## Operation

- State machine: IDLE, EXPAND, DONE.
- Reset, asynchronous: state=IDLE, every bank entry=0, words=0, round counter rnd=0, busy=0, ready=0.
- IDLE or DONE with start=1:
  - bank[0]<=key, rnd<=1, state<=EXPAND.
  - busy=1 and ready=0 from the next cycle.
- EXPAND, each cycle:
  - prev=bank[rnd-1], with words w0..w3 (w0 is the MSB word).
  - t = SubWord(RotWord(w3)) ^ Rcon[rnd]; RotWord = {w3[23:0], w3[31:24]}.
  - n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2; bank[rnd]<={n0,n1,n2,n3}.
  - If rnd==10: state<=DONE. Otherwise rnd<=rnd+1.
- DONE: ready=1, busy=0; the bank holds its value until the next accepted start or reset.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36, placed in the top byte; the low 24 bits are zero.
- start in EXPAND: ignored. No restart, no queueing.
- key changes outside an accepted start: no effect.
- Entries not yet rewritten during EXPAND keep their previous contents. Consumers gate on `ready`.
- rk_idx 11..15: rk=0.

## Timing

- Outputs busy and ready are registered. They are mutually exclusive; both are 0 in IDLE.
- Latency:
  - start sampled at edge E0 loads round 0.
  - Round r is written at edge E0+r.
  - ready rises after edge E0+10, i.e. 11 edges including the start edge.
  - busy is high for exactly 10 cycles.
- rk/words reflect the bank in the same cycle as the edge that wrote it. There is no extra read latency.
- Back-to-back: start in the first DONE cycle is accepted. ready drops after that edge.
- rst asserted mid-EXPAND: immediate return to the reset values. A later start performs a full expansion.

## Structure

- Shared package `aes_pkg`:
  - RCON constant array indexed 1..10.
  - round-key and bank width constants (128, 1408).
  - state enum {IDLE, EXPAND, DONE}.
- One natural sub-module: the existing `subword` (four `sbox` instances), instantiated once for the current round only. It is not replicated per round.
- Bank: 11x128 registers. `words` is a direct concatenation of the bank; no extra storage.

## Test plan

- Reset then idle: rst pulse, no start → ready=0, busy=0, words=0, rk=0 for all indices.
- FIPS-197 C.1 key: key=000102030405060708090a0b0c0d0e0f, start → after 11 edges ready=1.
  - rk_idx=1 → d6aa74fdd2af72fadaa678f1d6ab76fe.
  - rk_idx=10 → 13111d7fe3944a17f307a78b4d2b30c5.
  - words[1407:1280]=key.
- FIPS-197 A.1 key: key=2b7e151628aed2a6abf7158809cf4f3c, start issued in the DONE state of the previous run → rk_idx=1 → a0fafe1788542cb123a339392a6c7605; rk_idx=10 → d014f9a8c9ee2589e13f0cc8b6630ca6. busy=1 for exactly 10 cycles.
- start and key change mid-EXPAND (cycle 4, different key) → ignored; final bank matches the original key; ready timing unchanged.
- rst at cycle 5 of EXPAND → all outputs 0 asynchronously. A subsequent start with the C.1 key yields the correct round-10 key after 11 edges.
- rk_idx=12 while ready=1 → rk=0. Integration with the cipher on plaintext 00112233445566778899aabbccddeeff → ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.
